// File: rtl/pipe_addsub_nbits_if.sv
// Operand/result handshake bundle for the chunked add/subtract pipeline.
// The master side supplies operands and consumes results.
interface pipe_addsub_nbits_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ov;
  logic             zero;
  logic             neg;

  modport master (
    output flush, in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, s, co, ov, zero, neg
  );

  modport slave (
    input  flush, in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, s, co, ov, zero, neg
  );
endinterface

// File: rtl/pipe_addsub_nbits.sv
// WIDTH-bit add/subtract split into STAGES chunks, one chunk summed per stage,
// with the chunk carry registered between stages and ALU flags at the output.
module pipe_addsub_nbits #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  pipe_addsub_nbits_if.slave  bus
);
  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             cin);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
  endfunction

  function automatic logic [WIDTH-1:0] put_chunk(input logic [WIDTH-1:0] w,
                                                 input logic [CHUNK-1:0] c,
                                                 input int               idx);
    w[idx*CHUNK +: CHUNK] = c;
    return w;
  endfunction

  logic advance;

  // Stage inputs: opa carries finished low result chunks plus untouched high chunks of a
  logic [WIDTH-1:0] opa_in  [STAGES];
  logic [WIDTH-1:0] opb_in  [STAGES];
  logic             cy_in   [STAGES];
  logic             zr_in   [STAGES];
  logic             vld_in  [STAGES];
  logic [CHUNK:0]   sum_c   [STAGES];
  logic [WIDTH-1:0] opa_nxt [STAGES];
  logic             zr_nxt  [STAGES];
  logic             ov_nxt;

  // Pipeline registers, index k holds the state after chunk k has been summed
  logic [WIDTH-1:0] opa_p [STAGES];
  logic [WIDTH-1:0] opb_p [STAGES];
  logic             cy_p  [STAGES];
  logic             zr_p  [STAGES];
  logic             vld_p [STAGES];
  logic             ov_p;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign opa_in[k] = bus.a;
      assign opb_in[k] = bus.sub ? ~bus.b : bus.b;
      assign cy_in[k]  = bus.sub | bus.ci;
      assign zr_in[k]  = 1'b1;
      assign vld_in[k] = bus.in_valid;
    end else begin : g_next
      assign opa_in[k] = opa_p[k-1];
      assign opb_in[k] = opb_p[k-1];
      assign cy_in[k]  = cy_p[k-1];
      assign zr_in[k]  = zr_p[k-1];
      assign vld_in[k] = vld_p[k-1];
    end

    assign sum_c[k]   = add_chunk(opa_in[k][k*CHUNK +: CHUNK],
                                  opb_in[k][k*CHUNK +: CHUNK], cy_in[k]);
    assign opa_nxt[k] = put_chunk(opa_in[k], sum_c[k][CHUNK-1:0], k);
    assign zr_nxt[k]  = zr_in[k] & ~(|sum_c[k][CHUNK-1:0]);
  end

  // Top chunk is still unsummed at the last stage, so opa_in still holds a's MSB
  assign ov_nxt = (opa_in[LAST][WIDTH-1] == opb_in[LAST][WIDTH-1]) &&
                  (sum_c[LAST][CHUNK-1] != opa_in[LAST][WIDTH-1]);

  assign advance = !vld_p[LAST] || bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) vld_p[k] <= 1'b0;
    end else if (bus.flush) begin
      for (int k = 0; k < STAGES; k++) vld_p[k] <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) vld_p[k] <= vld_in[k];
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        opa_p[k] <= opa_nxt[k];
        opb_p[k] <= opb_in[k];
        cy_p[k]  <= sum_c[k][CHUNK];
        zr_p[k]  <= zr_nxt[k];
      end
      ov_p <= ov_nxt;
    end
  end

  // Output stage: data registers are unreset, so results are masked by valid
  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_p[LAST];
  assign bus.s         = vld_p[LAST] ? opa_p[LAST] : '0;
  assign bus.co        = vld_p[LAST] & cy_p[LAST];
  assign bus.ov        = vld_p[LAST] & ov_p;
  assign bus.zero      = vld_p[LAST] & zr_p[LAST];
  assign bus.neg       = vld_p[LAST] & opa_p[LAST][WIDTH-1];
endmodule
